// File: rtl/line_refill.sv
// line_refill: fetches one cache line as BEATS memory beats, packs them and writes the line to the data RAM.
// Critical-word-first fill order is enabled by defining LINE_REFILL_CWF_EN.
module line_refill #(
    parameter int LINE_W  = 128,
    parameter int BEAT_W  = 32,
    parameter int DEPTH   = 128,
    parameter int ADDRW   = $clog2(DEPTH),
    parameter int PADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDRW-1:0]   req_idx,
    input  logic [PADDR_W-1:0] req_addr,
    output logic               mem_ar_valid,
    input  logic               mem_ar_ready,
    output logic [PADDR_W-1:0] mem_ar_addr,
    input  logic               mem_r_valid,
    output logic               mem_r_ready,
    input  logic [BEAT_W-1:0]  mem_r_data,
    output logic               ram_we,
    output logic [ADDRW-1:0]   ram_a,
    output logic [LINE_W-1:0]  ram_di,
    output logic               done_valid,
    output logic [ADDRW-1:0]   done_idx
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LOFF  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                          state_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [ADDRW-1:0]                idx_q;
    logic [PADDR_W-1:0]              addr_q;
    logic [BEATS-1:0][BEAT_W-1:0]    line_q;

    logic [CNT_W-1:0]                off;
    logic [CNT_W:0]                  slot_sum;
    logic [CNT_W-1:0]                slot;
    logic                            beat_take;

`ifdef LINE_REFILL_CWF_EN
    localparam int BOFF = $clog2(BEAT_W / 8);
    localparam logic [PADDR_W-1:0] AR_MASK = ~PADDR_W'((64'd1 << BOFF) - 64'd1);
    // Memory returns a wrapping burst starting at the missed word.
    assign off = addr_q[LOFF-1:LOFF-CNT_W];
`else
    localparam logic [PADDR_W-1:0] AR_MASK = ~PADDR_W'((64'd1 << LOFF) - 64'd1);
    assign off = '0;
`endif

    assign beat_take = (state_q == DATA) && mem_r_valid;
    assign slot_sum  = {1'b0, off} + {1'b0, cnt_q};
    assign slot      = (slot_sum >= (CNT_W + 1)'(BEATS)) ? CNT_W'(slot_sum - (CNT_W + 1)'(BEATS))
                                                         : slot_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_idx;
                        addr_q  <= req_addr;
                        cnt_q   <= '0;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_ar_ready) state_q <= DATA;
                end
                DATA: begin
                    if (mem_r_valid) begin
                        if (cnt_q == CNT_W'(BEATS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= WRITE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                WRITE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Partial lines are discarded on reset; a new refill overwrites every slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (beat_take) begin
            line_q[slot] <= mem_r_data;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign mem_ar_valid = (state_q == ADDR);
    assign mem_r_ready  = (state_q == DATA);
    assign ram_we       = (state_q == WRITE);
    assign done_valid   = (state_q == WRITE);
    assign mem_ar_addr  = addr_q & AR_MASK;
    assign ram_a        = idx_q;
    assign done_idx     = idx_q;
    assign ram_di       = line_q;

endmodule

// File: tb/tb_line_refill.sv
// Directed self-checking bench for line_refill (default geometry: 128-bit line, 4 x 32-bit beats).
module tb_line_refill;
    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   req_idx;
    logic [31:0]  req_addr;
    logic         mem_ar_valid;
    logic         mem_ar_ready;
    logic [31:0]  mem_ar_addr;
    logic         mem_r_valid;
    logic         mem_r_ready;
    logic [31:0]  mem_r_data;
    logic         ram_we;
    logic [6:0]   ram_a;
    logic [127:0] ram_di;
    logic         done_valid;
    logic [6:0]   done_idx;

    int checks   = 0;
    int failures = 0;

    // Captures from the most recent refill transaction
    logic [31:0]  cap_ar_addr;
    logic [6:0]   cap_a;
    logic [127:0] cap_di;
    logic [6:0]   cap_done_idx;
    int cap_ar_cyc, cap_ar_cnt, cap_we_cnt, cap_we_cyc, cap_done_cnt, cap_ready_cyc, cap_wait;
    bit cap_timeout, cap_ar_unstable, cap_a_bad, cap_early_ready, cap_pulse_skew;

    line_refill dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_idx      (req_idx),
        .req_addr     (req_addr),
        .mem_ar_valid (mem_ar_valid),
        .mem_ar_ready (mem_ar_ready),
        .mem_ar_addr  (mem_ar_addr),
        .mem_r_valid  (mem_r_valid),
        .mem_r_ready  (mem_r_ready),
        .mem_r_data   (mem_r_data),
        .ram_we       (ram_we),
        .ram_a        (ram_a),
        .ram_di       (ram_di),
        .done_valid   (done_valid),
        .done_idx     (done_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and plays the memory side; cycle numbers count from the accept edge T.
    task automatic do_refill(input logic [6:0] idx, input logic [31:0] addr,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3,
                             input int ar_stall, input int r_gap, input bit hold9);
        logic [31:0] beats [4];
        int cyc, beat, stall, gap;
        bit ar_done, fin;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        cap_ar_addr = '0; cap_a = '0; cap_di = '0; cap_done_idx = '0;
        cap_ar_cyc = -1; cap_ar_cnt = 0; cap_we_cnt = 0; cap_we_cyc = -1;
        cap_done_cnt = 0; cap_ready_cyc = -1; cap_wait = 0;
        cap_timeout = 1'b1; cap_ar_unstable = 1'b0; cap_a_bad = 1'b0;
        cap_early_ready = 1'b0; cap_pulse_skew = 1'b0;
        while (!req_ready && cap_wait < 50) begin
            @(posedge clk); #1;
            cap_wait++;
        end
        req_valid = 1'b1; req_idx = idx; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0; beat = 0; stall = ar_stall; gap = 0; ar_done = 1'b0; fin = 1'b0;
        while (cyc < 300 && !fin) begin
            cyc++;
            mem_ar_ready = (stall == 0);
            mem_r_valid  = ar_done && (beat < 4) && (gap == 0);
            mem_r_data   = beats[beat & 3];
            req_valid    = hold9 && ar_done && (beat < 4);
            req_idx      = hold9 ? 7'd9 : idx;
            @(negedge clk);
            if (mem_ar_valid) begin
                if (cap_ar_cyc < 0) begin
                    cap_ar_cyc  = cyc;
                    cap_ar_addr = mem_ar_addr;
                end else if (mem_ar_addr !== cap_ar_addr) begin
                    cap_ar_unstable = 1'b1;
                end
                if (mem_ar_ready) begin
                    ar_done = 1'b1;
                    cap_ar_cnt++;
                end else if (stall > 0) begin
                    stall--;
                end
            end
            if (mem_r_valid && mem_r_ready) begin
                beat++;
                gap = r_gap;
            end else if (gap > 0) begin
                gap--;
            end
            if (mem_r_ready && ram_a !== idx) cap_a_bad = 1'b1;
            if (ram_we) begin
                cap_we_cnt++;
                cap_we_cyc = cyc;
                cap_a      = ram_a;
                cap_di     = ram_di;
            end
            if (done_valid) begin
                cap_done_cnt++;
                cap_done_idx = done_idx;
            end
            if (done_valid !== ram_we) cap_pulse_skew = 1'b1;
            if (req_ready && cap_we_cnt == 0) cap_early_ready = 1'b1;
            if (req_ready && cap_we_cnt > 0) begin
                cap_ready_cyc = cyc;
                cap_timeout   = 1'b0;
                fin           = 1'b1;
            end
            @(posedge clk); #1;
        end
        mem_ar_ready = 1'b0; mem_r_valid = 1'b0; req_valid = 1'b0;
        $display("refill idx=%0d addr=%h ar_addr=%h we_cyc=%0d a=%0d di=%h", idx, addr, cap_ar_addr,
                 cap_we_cyc, cap_a, cap_di);
    endtask

    task automatic test_reset();
        int we_seen;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({mem_ar_valid, mem_r_ready, ram_we, done_valid} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_ar_valid, mem_r_ready, ram_we, done_valid}); end
        checks++; if (ram_di !== 128'h0 || mem_ar_addr !== 32'h0) begin
            failures++; $display("FAIL reset_data got di=%h ar=%h exp=0", ram_di, mem_ar_addr); end
        checks++; if (ram_a !== 7'd0 || done_idx !== 7'd0) begin
            failures++; $display("FAIL reset_idx got a=%0d done_idx=%0d exp=0", ram_a, done_idx); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end

        // Reset in the middle of DATA after two beats
        req_valid = 1'b1; req_idx = 7'd7; req_addr = 32'h4000; mem_ar_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        mem_ar_ready = 1'b0; mem_r_valid = 1'b1; mem_r_data = 32'h55;
        @(posedge clk); #1;
        mem_r_data = 32'h66;
        @(posedge clk); #1;
        checks++; if (mem_r_ready !== 1'b1 || ram_di !== 128'h00000000_00000000_00000066_00000055) begin
            failures++; $display("FAIL mid_partial got rr=%b di=%h exp rr=1 di=..66_00000055", mem_r_ready, ram_di); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_ar_valid, mem_r_ready, ram_we, done_valid} !== 4'b0) begin
            failures++; $display("FAIL mid_rst_ctrl got=%b exp=0000", {mem_ar_valid, mem_r_ready, ram_we, done_valid}); end
        checks++; if (ram_di !== 128'h0 || mem_ar_addr !== 32'h0 || ram_a !== 7'd0 || done_idx !== 7'd0) begin
            failures++; $display("FAIL mid_rst_data got di=%h ar=%h a=%0d di_idx=%0d exp=0", ram_di, mem_ar_addr, ram_a, done_idx); end
        we_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ram_we || done_valid || mem_r_ready) we_seen++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ram_we || done_valid || mem_r_ready) we_seen++;
        end
        mem_r_valid = 1'b0;
        checks++; if (we_seen !== 0) begin
            failures++; $display("FAIL mid_rst_no_write got=%0d exp=0", we_seen); end
        checks++; if (req_ready !== 1'b1 || ram_di !== 128'h0) begin
            failures++; $display("FAIL mid_rst_release got rdy=%b di=%h exp rdy=1 di=0", req_ready, ram_di); end
        @(posedge clk); #1;
        $display("reset test done");
    endtask

    task automatic test_aligned();
        do_refill(7'd5, 32'h1000, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 1'b0);
        checks++; if (cap_timeout !== 1'b0) begin failures++; $display("FAIL aligned_timeout got=1 exp=0"); end
        checks++; if (cap_ar_addr !== 32'h1000 || cap_ar_cyc !== 1) begin
            failures++; $display("FAIL aligned_ar got addr=%h cyc=%0d exp addr=1000 cyc=1", cap_ar_addr, cap_ar_cyc); end
        checks++; if (cap_we_cyc !== 6 || cap_we_cnt !== 1) begin
            failures++; $display("FAIL aligned_we got cyc=%0d cnt=%0d exp cyc=6 cnt=1", cap_we_cyc, cap_we_cnt); end
        checks++; if (cap_a !== 7'd5) begin failures++; $display("FAIL aligned_a got=%0d exp=5", cap_a); end
        checks++; if (cap_di !== 128'h00000044_00000033_00000022_00000011) begin
            failures++; $display("FAIL aligned_di got=%h exp=00000044000000330000002200000011", cap_di); end
        checks++; if (cap_done_cnt !== 1 || cap_done_idx !== 7'd5 || cap_pulse_skew !== 1'b0) begin
            failures++; $display("FAIL aligned_done got cnt=%0d idx=%0d skew=%b exp 1/5/0", cap_done_cnt, cap_done_idx, cap_pulse_skew); end
        checks++; if (cap_ready_cyc !== 7) begin failures++; $display("FAIL aligned_ready got=%0d exp=7", cap_ready_cyc); end
        checks++; if (ram_a !== 7'd5 || done_idx !== 7'd5 || ram_di !== 128'h00000044_00000033_00000022_00000011) begin
            failures++; $display("FAIL aligned_hold got a=%0d idx=%0d di=%h exp a=5 idx=5 line held", ram_a, done_idx, ram_di); end
    endtask

    task automatic test_stalls();
        do_refill(7'd6, 32'h1000, 32'h11, 32'h22, 32'h33, 32'h44, 3, 2, 1'b0);
        checks++; if (cap_timeout !== 1'b0) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
        checks++; if (cap_ar_cyc !== 1 || cap_ar_cnt !== 1 || cap_ar_unstable !== 1'b0) begin
            failures++; $display("FAIL stall_ar got cyc=%0d cnt=%0d unstable=%b exp 1/1/0", cap_ar_cyc, cap_ar_cnt, cap_ar_unstable); end
        checks++; if (cap_we_cnt !== 1 || cap_we_cyc !== 15) begin
            failures++; $display("FAIL stall_we got cnt=%0d cyc=%0d exp cnt=1 cyc=15", cap_we_cnt, cap_we_cyc); end
        checks++; if (cap_di !== 128'h00000044_00000033_00000022_00000011 || cap_a !== 7'd6) begin
            failures++; $display("FAIL stall_line got a=%0d di=%h exp a=6 di=00000044000000330000002200000011", cap_a, cap_di); end
    endtask

    task automatic test_cwf();
        logic [31:0]  exp_ar;
        logic [127:0] exp_di;
`ifdef LINE_REFILL_CWF_EN
        exp_ar = 32'h1008;
        exp_di = {32'hBBBB0002, 32'hAAAA0001, 32'hDDDD0004, 32'hCCCC0003};
`else
        exp_ar = 32'h1000;
        exp_di = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
`endif
        do_refill(7'd3, 32'h1008, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 0, 0, 1'b0);
        checks++; if (cap_ar_addr !== exp_ar) begin
            failures++; $display("FAIL cwf_ar got=%h exp=%h", cap_ar_addr, exp_ar); end
        checks++; if (cap_di !== exp_di || cap_we_cnt !== 1) begin
            failures++; $display("FAIL cwf_di got=%h cnt=%0d exp=%h cnt=1", cap_di, cap_we_cnt, exp_di); end
    endtask

    task automatic test_ignore_req();
        do_refill(7'd12, 32'h5000, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 1'b1);
        checks++; if (cap_a !== 7'd12 || cap_done_idx !== 7'd12 || cap_a_bad !== 1'b0) begin
            failures++; $display("FAIL ignore_idx got a=%0d idx=%0d a_bad=%b exp 12/12/0", cap_a, cap_done_idx, cap_a_bad); end
        checks++; if (cap_early_ready !== 1'b0 || cap_we_cnt !== 1 || cap_ready_cyc !== 7) begin
            failures++; $display("FAIL ignore_accept got early=%b we=%0d rdy_cyc=%0d exp 0/1/7", cap_early_ready, cap_we_cnt, cap_ready_cyc); end
    endtask

    task automatic test_back_to_back();
        do_refill(7'd0, 32'h2000, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D, 0, 0, 1'b0);
        checks++; if (cap_a !== 7'd0 || cap_we_cnt !== 1 || cap_di !== 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A) begin
            failures++; $display("FAIL b2b_first got a=%0d cnt=%0d di=%h exp a=0 cnt=1", cap_a, cap_we_cnt, cap_di); end
        do_refill(7'd127, 32'h3FF0, 32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 0, 0, 1'b0);
        checks++; if (cap_wait !== 0) begin failures++; $display("FAIL b2b_wait got=%0d exp=0", cap_wait); end
        checks++; if (cap_a !== 7'd127 || cap_done_idx !== 7'd127 || cap_we_cnt !== 1) begin
            failures++; $display("FAIL b2b_second_idx got a=%0d idx=%0d cnt=%0d exp 127/127/1", cap_a, cap_done_idx, cap_we_cnt); end
        checks++; if (cap_di !== 128'hF0000004_F0000003_F0000002_F0000001 || cap_ar_addr !== 32'h3FF0) begin
            failures++; $display("FAIL b2b_second_line got di=%h ar=%h exp di=F0000004F0000003F0000002F0000001 ar=3ff0", cap_di, cap_ar_addr); end
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_idx = '0; req_addr = '0;
        mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_aligned();
        test_stalls();
        test_cwf();
        test_ignore_req();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
